prbs15_checker: RTL
===================

PRBS15_CHECKER -- requirements
Module: prbs15_checker

Interface
REQ-001 SHALL have parameter LOCK_COUNT, default 16, meaning consecutive matching words needed to enter LOCKED.
REQ-002 SHALL have parameter UNLOCK_COUNT, default 4, meaning consecutive mismatching words needed to return to SEARCH.
REQ-003 SHALL have parameter CNT_W, default 32, meaning width of all statistics counters.
REQ-004 SHALL have one clock and an asynchronous, active-high reset: clk  input  1  sole clock, all logic on rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous active-high reset.
REQ-006 SHALL have port data_in  input  8  received byte, same bit order as prbs15_byte.
REQ-007 SHALL have port data_valid  input  1  data_in is a stream word this cycle.
REQ-008 SHALL have port clear_counters  input  1  synchronous clear of word_count, err_word_count, bit_err_count.
REQ-009 SHALL have port locked  output  1  high in LOCKED state.
REQ-010 SHALL have port err_pulse  output  1  one-cycle strobe per mismatching compared word while LOCKED.
REQ-011 SHALL have port word_count  output  CNT_W  words compared while LOCKED.
REQ-012 SHALL have port err_word_count  output  CNT_W  mismatching words while LOCKED.
REQ-013 SHALL have port bit_err_count  output  CNT_W  sum of popcount(data_in XOR predicted) while LOCKED.

Function
REQ-014 SHALL predict each byte from the two preceding valid bytes via prbs15 (x^15+x^14+1) prediction; a word is "compared" only if it and the two preceding cycles all had data_valid=1.
REQ-015 SHALL treat any data_valid=0 cycle as a history break: next two valid words are history-fill only, not compared, not counted.
REQ-016 SHALL implement states SEARCH and LOCKED; reset state SEARCH.
REQ-017 SEARCH: match counter +1 per matching compared word, cleared on mismatch; at LOCK_COUNT -> LOCKED, match counter cleared.
REQ-018 LOCKED: miss counter +1 per mismatching compared word, cleared on match; at UNLOCK_COUNT -> SEARCH, match counter cleared.
REQ-019 Zero guard: a compared 0x00 word immediately following a valid 0x00 word SHALL count as mismatch in both states (all-zero stream never locks).
REQ-020 History break in SEARCH SHALL clear match counter; in LOCKED SHALL keep state and miss counter.
REQ-021 Statistics SHALL update only for compared words while LOCKED, including the word that causes unlock; the word that causes lock is not counted.
REQ-022 Outputs SHALL be registered: compare result of data_in at cycle n visible on locked/err_pulse/counters at cycle n+1.
REQ-023 Counters SHALL saturate at 2^CNT_W-1; bit_err_count adds 0..8 per word, clamped.
REQ-024 clear_counters asserted together with an increment SHALL yield 0 (clear wins); state machine unaffected by clear_counters.

Reset
REQ-025 rst SHALL asynchronously force SEARCH, locked=0, err_pulse=0, all counters 0, match/miss counters 0, history marked invalid.
REQ-026 Release of rst SHALL require two valid words of history fill before first compare.

Structure
REQ-027 State encoding typedef and default LOCK_COUNT/UNLOCK_COUNT constants SHALL live in a shared prbs package.
REQ-028 Prediction SHALL be one sub-module instance, prbs15_byte, fed data_in; checker aligns its registered output with the current word.
REQ-029 Popcount SHALL be a local function, not a separate module.

Verification
REQ-030 Reset, then continuous valid PRBS15 stream -> locked rises at cycle of compared word 16 +1; counters 0 at lock; word_count increments 1/cycle thereafter.
REQ-031 Locked, inject data_in XOR 0x81 on one word -> err_pulse one cycle, err_word_count=1, bit_err_count=2, locked stays 1.
REQ-032 Locked, four consecutive corrupted words -> locked falls after 4th; err_word_count=4; relock after 16 clean compared words.
REQ-033 Continuous valid 0x00 stream -> locked never asserts; counters stay 0.
REQ-034 Locked, data_valid low one cycle mid-stream -> next two words uncounted, no err_pulse, locked stays 1; word_count skips 3.
REQ-035 clear_counters coincident with an error word -> all counters 0 next cycle; rst mid-LOCKED -> locked=0 asynchronously.

Source files
------------

// File: rtl/prbs15_checker_pkg.sv
// Shared definitions for the PRBS15 checker: state encoding, default lock thresholds
// and the byte-wide x^15+x^14+1 prediction function.
package prbs15_checker_pkg;

    typedef enum logic [0:0] {
        ST_SEARCH = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    localparam int DEF_LOCK_COUNT   = 16;
    localparam int DEF_UNLOCK_COUNT = 4;

    // Bytes are sent MSB first, so {prev2, prev1} bit i holds serial bit s[n-1-i].
    // Each new bit obeys s[n] = s[n-14] ^ s[n-15].
    function automatic logic [7:0] prbs15_next(input logic [7:0] prev2, input logic [7:0] prev1);
        logic [15:0] h;
        logic [7:0]  p;
        h = {prev2, prev1};
        p = '0;
        for (int j = 0; j < 8; j++) begin
            p[7-j] = h[13-j] ^ h[14-j];
        end
        return p;
    endfunction

endpackage

// File: rtl/prbs15_byte.sv
// Byte-wide PRBS15 predictor: keeps two bytes of history and registers the predicted next byte.
// With i_load low the history advances on its own prediction (flywheel) instead of i_data.
module prbs15_byte
    import prbs15_checker_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [7:0] i_data,
    input  logic       i_load,
    output logic [7:0] o_pred
);

    logic [7:0] r_prev;
    logic [7:0] r_pred;
    logic [7:0] w_cur;

    assign w_cur = i_load ? i_data : r_pred;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_prev <= '0;
            r_pred <= '0;
        end else begin
            r_prev <= w_cur;
            r_pred <= prbs15_next(r_prev, w_cur);
        end
    end

    assign o_pred = r_pred;

endmodule

// File: rtl/prbs15_checker.sv
// PRBS15 receive checker: SEARCH/LOCKED synchronisation with match/miss hysteresis and
// saturating word, error-word and bit-error statistics gathered while LOCKED.
module prbs15_checker
    import prbs15_checker_pkg::*;
#(
    parameter int LOCK_COUNT   = DEF_LOCK_COUNT,
    parameter int UNLOCK_COUNT = DEF_UNLOCK_COUNT,
    parameter int CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       data_in,
    input  logic             data_valid,
    input  logic             clear_counters,
    output logic             locked,
    output logic             err_pulse,
    output logic [CNT_W-1:0] word_count,
    output logic [CNT_W-1:0] err_word_count,
    output logic [CNT_W-1:0] bit_err_count,
    output state_t           o_dbg_state
);

    localparam int MW = $clog2(LOCK_COUNT + 1);
    localparam int XW = $clog2(UNLOCK_COUNT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    function automatic logic [3:0] popcount8(input logic [7:0] v);
        logic [3:0] c;
        c = '0;
        for (int i = 0; i < 8; i++) begin
            c = c + {3'b000, v[i]};
        end
        return c;
    endfunction

    state_t           r_state, w_state_nx;
    logic [MW-1:0]    r_match, w_match_nx;
    logic [XW-1:0]    r_miss, w_miss_nx;
    logic             r_v1, r_v2, r_prev_zero;
    logic [CNT_W-1:0] r_word_count, r_err_word_count, r_bit_err_count;
    logic             r_err_pulse;
    logic [7:0]       w_pred;
    logic             w_compared, w_mismatch, w_count_en;
    logic [CNT_W:0]   w_bec_sum;

    // data_valid is a valid-only stream with no ready: a word is consumed in every cycle it is high.
    assign w_compared = data_valid & r_v1 & r_v2;
    assign w_mismatch = (data_in != w_pred) | ((data_in == 8'h00) & r_prev_zero);
    assign w_count_en = (r_state == ST_LOCKED) & w_compared;

    // Once locked, compared words advance the predictor on its own output so a corrupted
    // word does not poison the next two predictions.
    prbs15_byte u_pred (
        .i_clk  (clk),
        .i_rst  (rst),
        .i_data (data_in),
        .i_load (~w_count_en),
        .o_pred (w_pred)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_SEARCH;
            r_match     <= '0;
            r_miss      <= '0;
            r_v1        <= 1'b0;
            r_v2        <= 1'b0;
            r_prev_zero <= 1'b0;
        end else begin
            r_state     <= w_state_nx;
            r_match     <= w_match_nx;
            r_miss      <= w_miss_nx;
            r_v1        <= data_valid;
            r_v2        <= r_v1;
            r_prev_zero <= data_valid & (data_in == 8'h00);
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_match_nx = r_match;
        w_miss_nx  = r_miss;
        case (r_state)
            ST_SEARCH: begin
                if (!data_valid) begin
                    w_match_nx = '0;
                end else if (w_compared) begin
                    if (w_mismatch) begin
                        w_match_nx = '0;
                    end else if (r_match == MW'(LOCK_COUNT - 1)) begin
                        w_state_nx = ST_LOCKED;
                        w_match_nx = '0;
                        w_miss_nx  = '0;
                    end else begin
                        w_match_nx = r_match + MW'(1);
                    end
                end
            end
            ST_LOCKED: begin
                if (w_compared) begin
                    if (!w_mismatch) begin
                        w_miss_nx = '0;
                    end else if (r_miss == XW'(UNLOCK_COUNT - 1)) begin
                        w_state_nx = ST_SEARCH;
                        w_miss_nx  = '0;
                        w_match_nx = '0;
                    end else begin
                        w_miss_nx = r_miss + XW'(1);
                    end
                end
            end
            default: w_state_nx = ST_SEARCH;
        endcase
    end

    assign w_bec_sum = {1'b0, r_bit_err_count} + (CNT_W + 1)'(popcount8(data_in ^ w_pred));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_word_count     <= '0;
            r_err_word_count <= '0;
            r_bit_err_count  <= '0;
            r_err_pulse      <= 1'b0;
        end else begin
            r_err_pulse <= w_count_en & w_mismatch;
            if (clear_counters) begin
                r_word_count     <= '0;
                r_err_word_count <= '0;
                r_bit_err_count  <= '0;
            end else if (w_count_en) begin
                if (r_word_count != CNT_MAX) r_word_count <= r_word_count + CNT_W'(1);
                if (w_mismatch && (r_err_word_count != CNT_MAX)) r_err_word_count <= r_err_word_count + CNT_W'(1);
                r_bit_err_count <= w_bec_sum[CNT_W] ? CNT_MAX : w_bec_sum[CNT_W-1:0];
            end
        end
    end

    assign locked         = (r_state == ST_LOCKED);
    assign err_pulse      = r_err_pulse;
    assign word_count     = r_word_count;
    assign err_word_count = r_err_word_count;
    assign bit_err_count  = r_bit_err_count;
    assign o_dbg_state    = r_state;

endmodule
